// File: rtl/com_pkg.sv
// Shared types for the command-bus transmitter.
// Opcodes, word counts, bus word type, FSM states.
package com_pkg;

  typedef enum logic [1:0] {
    OP_RSVD     = 2'd0,
    OP_FLIP     = 2'd1,
    OP_POLYLINE = 2'd2,
    OP_TRIANGLE = 2'd3
  } op_e;

  localparam int unsigned NW_FLIP = 1;
  localparam int unsigned NW_POLY = 6;
  localparam int unsigned NW_TRI  = 8;

  typedef logic [8:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  typedef struct packed {
    op_e        op;
    word_t      color;
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
    logic [7:0] x2;
    logic [7:0] y2;
  } cmd_t;

  function automatic logic [2:0] last_idx(
    input op_e op
  );
    case (op)
      OP_FLIP:     return 3'(NW_FLIP - 1);
      OP_POLYLINE: return 3'(NW_POLY - 1);
      OP_TRIANGLE: return 3'(NW_TRI - 1);
      default:     return 3'd0;
    endcase
  endfunction

  function automatic word_t word_at(
    input cmd_t       c,
    input logic [2:0] i
  );
    case (i)
      3'd0:    return {7'd0, c.op};
      3'd1:    return c.color;
      3'd2:    return {1'b0, c.x0};
      3'd3:    return {1'b0, c.y0};
      3'd4:    return {1'b0, c.x1};
      3'd5:    return {1'b0, c.y1};
      3'd6:    return {1'b0, c.x2};
      default: return {1'b0, c.y2};
    endcase
  endfunction

endpackage

// File: rtl/com_tx_sync2.sv
// Two-flop synchronizer for the asynchronous frame input.
// Ports: iClk, iRst_ (async low), iD in, oQ synchronized out.
module sync2 (
  input  logic iClk,
  input  logic iRst_,
  input  logic iD,
  output logic oQ
);

  logic [1:0] ff_q;

  always_ff @(posedge iClk or negedge iRst_) begin
    if (!iRst_) ff_q <= '0;
    else        ff_q <= {ff_q[0], iD};
  end

  assign oQ = ff_q[1];

endmodule

// File: rtl/com_tx.sv
// Serializes flip/polyline/triangle commands onto the D/Cmd/Go bus.
// In: iClk, iRst_, iGo, iOp, iColor, coords, iFrame. Out: oD, oCmd, oGo, oBusy, oDone, oErr.
module com_tx
  import com_pkg::*;
#(
  parameter int STROBE_LO  = 4,
  parameter int STROBE_HI  = 4,
  parameter bit WAIT_FRAME = 1'b0
) (
  input  logic       iClk,
  input  logic       iRst_,
  input  logic       iGo,
  input  logic [1:0] iOp,
  input  logic [8:0] iColor,
  input  logic [7:0] iX0,
  input  logic [7:0] iY0,
  input  logic [7:0] iX1,
  input  logic [7:0] iY1,
  input  logic [7:0] iX2,
  input  logic [7:0] iY2,
  input  logic       iFrame,
  output logic [8:0] oD,
  output logic       oCmd,
  output logic       oGo,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  localparam int MAXP =
    (STROBE_LO > STROBE_HI) ? STROBE_LO : STROBE_HI;
  localparam int PW = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam logic [PW-1:0] LO_END = PW'(STROBE_LO - 1);
  localparam logic [PW-1:0] HI_END = PW'(STROBE_HI - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    widx_q, widx_d;
  cmd_t          cmd_q, cmd_d;
  word_t         d_q, d_d;
  logic          cmdw_q, cmdw_d;
  logic          go_q, go_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          frame_s, frame_prev_q;
  logic          frame_rise;
  logic          load;

  sync2 u_sync (
    .iClk  (iClk),
    .iRst_ (iRst_),
    .iD    (iFrame),
    .oQ    (frame_s)
  );

  assign frame_rise = frame_s & ~frame_prev_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    widx_d  = widx_q;
    cmd_d   = cmd_q;
    d_d     = d_q;
    cmdw_d  = cmdw_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (iGo) begin
          if (op_e'(iOp) == OP_RSVD) begin
            err_d = 1'b1;
          end else begin
            cmd_d.op    = op_e'(iOp);
            cmd_d.color = iColor;
            cmd_d.x0    = iX0;
            cmd_d.y0    = iY0;
            cmd_d.x1    = iX1;
            cmd_d.y1    = iY1;
            cmd_d.x2    = iX2;
            cmd_d.y2    = iY2;
            widx_d      = '0;
            phase_d     = '0;
            if (WAIT_FRAME && op_e'(iOp) == OP_FLIP) begin
              state_d = S_SYNC;
            end else begin
              state_d = S_SETUP;
              load    = 1'b1;
            end
          end
        end
      end
      S_SYNC: begin
        if (frame_rise) begin
          state_d = S_SETUP;
          phase_d = '0;
          load    = 1'b1;
        end
      end
      S_SETUP: begin
        if (phase_q == LO_END) begin
          state_d = S_STROBE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_STROBE: begin
        if (phase_q == HI_END) begin
          state_d = S_HOLD;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_HOLD: begin
        if (widx_q == last_idx(cmd_q.op)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SETUP;
          widx_d  = widx_q + 3'd1;
          phase_d = '0;
          load    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Bus data only moves when a word enters SETUP.
    if (load) begin
      d_d    = word_at(cmd_d, widx_d);
      cmdw_d = (widx_d == 3'd0);
    end
    go_d   = (state_d == S_STROBE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iClk or negedge iRst_) begin
    if (!iRst_) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      widx_q       <= '0;
      cmd_q        <= '0;
      d_q          <= '0;
      cmdw_q       <= 1'b0;
      go_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      frame_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      widx_q       <= widx_d;
      cmd_q        <= cmd_d;
      d_q          <= d_d;
      cmdw_q       <= cmdw_d;
      go_q         <= go_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      frame_prev_q <= frame_s;
    end
  end

  assign oD    = d_q;
  assign oCmd  = cmdw_q;
  assign oGo   = go_q;
  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oErr  = err_q;

endmodule

// File: tb/tb_com_tx.sv
// Directed bench for com_tx: table vectors on default timing,
// fast-strobe triangle, frame-wait flip and mid-transfer reset.
module tb_com_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] go;
  logic [1:0] op;
  logic [8:0] color;
  logic [7:0] x0, y0, x1, y1, x2, y2;
  logic       frame;

  logic [8:0] d   [3];
  logic       cmd [3];
  logic       gox [3];
  logic       bsy [3];
  logic       dne [3];
  logic       err [3];
  logic [13:0] obs [3];

  logic [8:0] pd [3];
  logic       pc [3];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]      op;
    logic [8:0]      color;
    logic [7:0]      x0, y0, x1, y1, x2, y2;
    int              nw;
    logic [7:0][8:0] w;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  com_tx u0 (
    .iClk(clk), .iRst_(rst_n), .iGo(go[0]), .iOp(op),
    .iColor(color), .iX0(x0), .iY0(y0), .iX1(x1),
    .iY1(y1), .iX2(x2), .iY2(y2), .iFrame(frame),
    .oD(d[0]), .oCmd(cmd[0]), .oGo(gox[0]),
    .oBusy(bsy[0]), .oDone(dne[0]), .oErr(err[0])
  );

  com_tx #(.STROBE_LO(1), .STROBE_HI(1)) u1 (
    .iClk(clk), .iRst_(rst_n), .iGo(go[1]), .iOp(op),
    .iColor(color), .iX0(x0), .iY0(y0), .iX1(x1),
    .iY1(y1), .iX2(x2), .iY2(y2), .iFrame(frame),
    .oD(d[1]), .oCmd(cmd[1]), .oGo(gox[1]),
    .oBusy(bsy[1]), .oDone(dne[1]), .oErr(err[1])
  );

  com_tx #(.WAIT_FRAME(1'b1)) u2 (
    .iClk(clk), .iRst_(rst_n), .iGo(go[2]), .iOp(op),
    .iColor(color), .iX0(x0), .iY0(y0), .iX1(x1),
    .iY1(y1), .iX2(x2), .iY2(y2), .iFrame(frame),
    .oD(d[2]), .oCmd(cmd[2]), .oGo(gox[2]),
    .oBusy(bsy[2]), .oDone(dne[2]), .oErr(err[2])
  );

  // {busy, done, err, go, cmd, d[8:0]}
  for (genvar k = 0; k < 3; k++) begin : g_obs
    assign obs[k] = {bsy[k], dne[k], err[k],
                     gox[k], cmd[k], d[k]};
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    op    = v.op;
    color = v.color;
    x0 = v.x0; y0 = v.y0;
    x1 = v.x1; y1 = v.y1;
    x2 = v.x2; y2 = v.y2;
  endtask

  task automatic run(input int s, input vec_t v,
                     input int lo, input int hi,
                     input bit rep);
    int p, span, last, pulses, dchg, n, r;
    logic       go_prev;
    logic [8:0] d_prev;
    logic [13:0] e;
    p = lo + hi + 1;
    span = p * v.nw;
    last = (v.nw == 0) ? 4 : span + 3;
    pulses = 0;
    dchg = 0;
    go_prev = 1'b0;
    d_prev = pd[s];
    apply(v);
    @(negedge clk);
    go[s] = 1'b1;
    @(posedge clk);
    #1;
    go[s] = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (v.nw == 0) begin
        e = {1'b0, 1'b0, (c == 1), 1'b0, pc[s], pd[s]};
      end else if (c <= span) begin
        n = (c - 1) / p;
        r = (c - 1) % p;
        e = {1'b1, 1'b0, 1'b0, (r >= lo && r < lo + hi),
             (n == 0), v.w[n]};
      end else begin
        e = {1'b0, (c == span + 1), 1'b0, 1'b0,
             (v.nw == 1), v.w[v.nw-1]};
      end
      chk($sformatf("dut%0d op%0d cyc%0d", s, v.op, c),
          obs[s], e);
      if (obs[s][10] && !go_prev) pulses++;
      if (go_prev && obs[s][8:0] !== d_prev) dchg++;
      go_prev = obs[s][10];
      d_prev  = obs[s][8:0];
      if (rep && c == 10) begin
        go[s] = 1'b1;
        op = 2'd1;
        x0 = 8'h55;
      end
      if (rep && c == 11) go[s] = 1'b0;
      @(posedge clk);
      #1;
    end
    chk($sformatf("dut%0d op%0d pulses", s, v.op),
        pulses, v.nw);
    chk($sformatf("dut%0d op%0d d moved under go", s, v.op),
        dchg, 0);
    if (v.nw > 0) begin
      pd[s] = v.w[v.nw-1];
      pc[s] = (v.nw == 1);
    end
  endtask

  initial begin
    int g, dn;
    tbl[0] = '{2'd0, 9'h1AB, 8'd1, 8'd2, 8'd3, 8'd4,
               8'd5, 8'd6, 0, 72'h0};
    tbl[1] = '{2'd1, 9'h000, 8'd0, 8'd0, 8'd0, 8'd0,
               8'd0, 8'd0, 1, 72'h1};
    tbl[2] = '{2'd2, 9'h1C0, 8'd10, 8'd20, 8'd200, 8'd100,
               8'd0, 8'd0, 6,
               {9'h000, 9'h000, 9'h064, 9'h0C8,
                9'h014, 9'h00A, 9'h1C0, 9'h002}};
    tbl[3] = '{2'd3, 9'h03F, 8'd1, 8'd2, 8'd255, 8'd128,
               8'd64, 8'd7, 8,
               {9'h007, 9'h040, 9'h080, 9'h0FF,
                9'h002, 9'h001, 9'h03F, 9'h003}};
    for (int s = 0; s < 3; s++) begin
      pd[s] = '0;
      pc[s] = 1'b0;
    end
    go = '0;
    frame = 1'b1;
    apply(tbl[0]);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int s = 0; s < 3; s++)
      chk($sformatf("reset dut%0d", s), obs[s], 14'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run(0, tbl[i], 4, 4, 1'b0);

    run(1, tbl[3], 1, 1, 1'b1);

    apply(tbl[1]);
    @(negedge clk);
    go[2] = 1'b1;
    @(posedge clk);
    #1;
    go[2] = 1'b0;
    g = 0;
    dn = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c <= 22)
        chk($sformatf("sync hold cyc%0d", c),
            {obs[2][10], obs[2][8:0]}, 10'h0);
      if (obs[2][10] && g == 0) begin
        g = c;
        chk("sync word", obs[2][9:0], {1'b1, 9'h001});
      end
      if (obs[2][12]) dn = c;
      if (c == 5) frame = 1'b0;
      if (c == 20) frame = 1'b1;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (g < 26 || g > 28) begin
      n_fail++;
      $display("FAIL sync go rise: cycle %0d, expected 26..28", g);
    end
    chk("sync done", dn, g + 5);

    apply(tbl[2]);
    @(negedge clk);
    go[0] = 1'b1;
    @(posedge clk);
    #1;
    go[0] = 1'b0;
    for (int c = 1; c < 24; c++) begin
      @(posedge clk);
      #1;
    end
    chk("third pulse go", obs[0][10], 1);
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++)
      chk($sformatf("async reset dut%0d", s), obs[s], 14'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      pd[s] = '0;
      pc[s] = 1'b0;
    end
    run(0, tbl[1], 4, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
